freq_div_ctrl: RTL and testbench

//  Programmable clock-enable divider controller. It sequences a W-bit magnitude

---
 rtl/fd_pkg.sv | 16 +
 rtl/freq_div_ctrl_if.sv | 32 +++
 rtl/fd_cmp.sv | 21 ++
 rtl/freq_div_ctrl.sv | 124 ++++++++++++
 tb/tb_freq_div_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fd_pkg.sv
// Shared definitions for the programmable clock-enable divider controller.
//   state_t     : controller FSM state (IDLE / RUN / STOP), 2-bit encoded
//   FD_W        : default counter/divisor width
//   FD_DEF_DIV  : default divisor loaded at reset
package fd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int FD_W       = 4;
  localparam int FD_DEF_DIV = 5;

endpackage

// File: rtl/freq_div_ctrl_if.sv
// Control/status bundle between config logic (master) and the divider
// controller (slave).
//   en         : run request (level)
//   cfg_valid  : new divisor offered
//   cfg_div    : offered divisor N
//   cfg_ready  : controller can take a divisor
//   cfg_err    : 1-cycle pulse, accepted divisor was 0 and was dropped
//   clk_out    : divided clock, 50% duty, period 2*N
//   tick       : 1-cycle pulse at each clk_out edge
//   busy       : controller not idle
interface freq_div_ctrl_if #(
  parameter int W = 4
);
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clk_out;
  logic         tick;
  logic         busy;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, clk_out, tick, busy
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, clk_out, tick, busy
  );
endinterface

// File: rtl/fd_cmp.sv
// W-bit magnitude comparator slice (combinational).
//   a, b     : operands
//   casc_in  : equality from the more significant slice; qualifies all
//              outputs so a chain only resolves in the first unequal slice
//   gt/lt/eq : a>b, a<b, a==b (each gated by casc_in)
module fd_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         casc_in,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  assign gt = casc_in & (a >  b);
  assign lt = casc_in & (a <  b);
  assign eq = casc_in & (a == b);

endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable clock-enable divider controller.
// A free-running W-bit count is compared against div-1; each terminal count
// (TC) clears the count, toggles clk_out and pulses tick, giving a 50% duty
// clk_out of period 2*N. New divisors arrive over a valid/ready handshake;
// while running they are parked in a pending register and applied on the
// next TC so the count never passes div-1.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : freq_div_ctrl_if slave (en, cfg_*, clk_out, tick, busy)
module freq_div_ctrl
  import fd_pkg::*;
#(
  parameter int W       = FD_W,
  parameter int DEF_DIV = FD_DEF_DIV
) (
  input logic            clk,
  input logic            rst,
  freq_div_ctrl_if.slave bus
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] DEFV = W'(DEF_DIV);

  state_t       state;
  logic [W-1:0] count;
  logic [W-1:0] div;
  logic [W-1:0] pend_div;
  logic         pend_vld;
  logic         clk_out_q;
  logic         tick_q;
  logic         err_q;

  logic [W-1:0] div_m1;
  logic         cmp_gt, cmp_lt, cmp_eq;
  logic         tc;
  logic         accept;

  // div is never 0, so div-1 cannot underflow.
  assign div_m1 = div - ONE;

  fd_cmp #(.W(W)) u_cmp (
    .a       (count),
    .b       (div_m1),
    .casc_in (1'b1),
    .gt      (cmp_gt),
    .lt      (cmp_lt),
    .eq      (cmp_eq)
  );

  assign tc     = cmp_eq & (state != IDLE);
  assign accept = bus.cfg_valid & ~pend_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      div       <= DEFV;
      pend_div  <= '0;
      pend_vld  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      err_q  <= 1'b0;

      case (state)
        IDLE: begin
          count     <= '0;
          clk_out_q <= 1'b0;
          if (bus.en) state <= RUN;
        end
        RUN, STOP: begin
          if (tc) begin
            count     <= '0;
            clk_out_q <= ~clk_out_q;
            tick_q    <= 1'b1;
            // Swap divisor in the same cycle the count clears.
            if (pend_vld) begin
              div      <= pend_div;
              pend_vld <= 1'b0;
            end
          end else begin
            count <= count + ONE;
          end

          // en wins over the stop sequence; STOP only retires on the TC
          // that takes clk_out low, so the output always parks low.
          if (bus.en)
            state <= RUN;
          else if (state == RUN)
            state <= STOP;
          else if (tc && clk_out_q)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // accept implies pend_vld==0, so this never collides with the TC swap.
      if (accept) begin
        if (bus.cfg_div == '0) begin
          err_q <= 1'b1;
        end else if (state == IDLE) begin
          div <= bus.cfg_div;
        end else begin
          pend_div <= bus.cfg_div;
          pend_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.clk_out   = clk_out_q;
  assign bus.tick      = tick_q;
  assign bus.cfg_err   = err_q;
  assign bus.cfg_ready = ~pend_vld;
  assign bus.busy      = (state != IDLE);

  // Count overrun: count must stay at or below div-1.
  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    !cmp_gt && (cmp_lt ^ cmp_eq));

endmodule

// File: tb/tb_freq_div_ctrl.sv
module tb_freq_div_ctrl;

  logic clk;
  logic rst;

  freq_div_ctrl_if #(.W(4)) bus ();

  freq_div_ctrl #(.W(4), .DEF_DIV(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard: expected clk_out half-period lengths, in clk cycles.
  int  exp_q[$];
  bit  mark = 0;
  bit  mon_on = 0;
  int  cyc = 0;
  int  last_edge = 0;
  logic prev_co = 1'b0;

  task automatic push_n(input int n, input int len);
    for (int i = 0; i < n; i++) exp_q.push_back(len);
  endtask

  // Monitor on the falling edge, away from the edges where state changes.
  initial begin
    forever begin
      @(negedge clk);
      if (mark) begin
        last_edge = cyc;
        prev_co   = bus.clk_out;
        mon_on    = 1;
        mark      = 0;
      end else if (mon_on) begin
        logic edge_seen;
        edge_seen = (bus.clk_out !== prev_co);
        if (edge_seen) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected clk_out edge at cycle %0d: got edge expected none", cyc);
          end else begin
            int e;
            e = exp_q.pop_front();
            chk("half period", cyc - last_edge, e);
          end
          last_edge = cyc;
          prev_co   = bus.clk_out;
        end
        chk("tick vs clk_out edge", bus.tick, edge_seen);
      end
      if (!rst) chk("comparator gt", dut.cmp_gt, 0);
      cyc++;
    end
  end

  typedef struct {
    logic       en;
    logic       v;
    logic [3:0] d;
    logic       co;
    logic       tk;
    logic       rdy;
    logic       err;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic v, input logic [3:0] d,
                     input logic co, input logic tk, input logic rdy,
                     input logic err, input logic bsy);
    vec_t x;
    x.en = en; x.v = v; x.d = d;
    x.co = co; x.tk = tk; x.rdy = rdy; x.err = err; x.bsy = bsy;
    tbl.push_back(x);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while (bus.busy && n < maxc) begin
      step();
      n++;
    end
    chk(name, bus.busy, 0);
  endtask

  initial begin
    int n;

    //        en v d   co tk rdy err bsy
    add(0, 1, 4'd3, 0, 0, 1, 0, 0); // load N=3 in IDLE
    add(1, 0, 4'd0, 0, 0, 1, 0, 1); // enter RUN
    add(1, 0, 4'd0, 0, 0, 1, 0, 1);
    add(1, 0, 4'd0, 0, 0, 1, 0, 1);
    add(1, 0, 4'd0, 1, 1, 1, 0, 1); // first rise, 3 cycles after RUN
    add(1, 0, 4'd0, 1, 0, 1, 0, 1);
    add(1, 0, 4'd0, 1, 0, 1, 0, 1);
    add(1, 0, 4'd0, 0, 1, 1, 0, 1);
    add(1, 0, 4'd0, 0, 0, 1, 0, 1);
    add(1, 0, 4'd0, 0, 0, 1, 0, 1);
    add(1, 0, 4'd0, 1, 1, 1, 0, 1);
    add(1, 1, 4'd0, 1, 0, 1, 1, 1); // zero divisor: err pulse
    add(1, 0, 4'd0, 1, 0, 1, 0, 1);
    add(1, 0, 4'd0, 0, 1, 1, 0, 1); // still N=3
    add(1, 1, 4'd6, 0, 0, 0, 0, 1); // N=6 pending
    add(1, 0, 4'd0, 0, 0, 0, 0, 1);
    add(1, 0, 4'd0, 1, 1, 1, 0, 1); // applied at TC
    add(1, 0, 4'd0, 1, 0, 1, 0, 1);
    add(1, 0, 4'd0, 1, 0, 1, 0, 1);
    add(1, 0, 4'd0, 1, 0, 1, 0, 1);
    add(1, 0, 4'd0, 1, 0, 1, 0, 1);
    add(1, 0, 4'd0, 1, 0, 1, 0, 1);
    add(1, 0, 4'd0, 0, 1, 1, 0, 1); // 6-cycle half period

    bus.en = 0; bus.cfg_valid = 0; bus.cfg_div = '0;
    rst = 1;
    #20;
    chk("reset clk_out", bus.clk_out, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset cfg_ready", bus.cfg_ready, 1);
    chk("reset tick", bus.tick, 0);
    chk("reset cfg_err", bus.cfg_err, 0);
    chk("reset div", dut.div, 5);
    #30;
    rst = 0;

    foreach (tbl[i]) begin
      bus.en = tbl[i].en; bus.cfg_valid = tbl[i].v; bus.cfg_div = tbl[i].d;
      step();
      chk($sformatf("vec%0d clk_out", i), bus.clk_out, tbl[i].co);
      chk($sformatf("vec%0d tick", i), bus.tick, tbl[i].tk);
      chk($sformatf("vec%0d cfg_ready", i), bus.cfg_ready, tbl[i].rdy);
      chk($sformatf("vec%0d cfg_err", i), bus.cfg_err, tbl[i].err);
      chk($sformatf("vec%0d busy", i), bus.busy, tbl[i].bsy);
    end

    // Stop from a low phase at N=6 and return to IDLE.
    bus.en = 0; bus.cfg_valid = 0;
    wait_idle("idle after N=6", 40);

    // N=4: stop requested in the high phase.
    bus.cfg_valid = 1; bus.cfg_div = 4'd4;
    step();
    bus.cfg_valid = 0; bus.en = 1;
    step();                     // enters RUN
    mark = 1;
    push_n(6, 4);
    steps(21);
    bus.en = 0;
    steps(2);                   // 23 cycles in: still high, in STOP
    chk("stop high clk_out", bus.clk_out, 1);
    chk("stop high busy", bus.busy, 1);
    step();                     // 24: falling edge and IDLE together
    chk("stop fall clk_out", bus.clk_out, 0);
    chk("stop fall busy", bus.busy, 0);
    chk("stop fall tick", bus.tick, 1);
    steps(3);
    chk("idle stays low", bus.clk_out, 0);
    chk("N=4 edges all seen", exp_q.size(), 0);
    mon_on = 0;

    // N=4: stop in the low phase, resume during STOP.
    bus.en = 1;
    step();
    mark = 1;
    push_n(8, 4);
    steps(9);
    bus.en = 0;
    steps(4);                   // 13: rise at 12 happened in STOP
    chk("resume STOP busy", bus.busy, 1);
    chk("resume STOP clk_out", bus.clk_out, 1);
    bus.en = 1;
    steps(13);                  // 26
    chk("resume busy", bus.busy, 1);
    chk("resume edges so far", exp_q.size(), 2);
    bus.en = 0;
    wait_idle("idle after resume", 20);
    step();
    chk("resume edges all seen", exp_q.size(), 0);
    mon_on = 0;

    // N=1: toggle every cycle, tick held high.
    bus.cfg_valid = 1; bus.cfg_div = 4'd1;
    step();
    bus.cfg_valid = 0; bus.en = 1;
    step();
    mark = 1;
    push_n(5, 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("N=1 tick %0d", k), bus.tick, 1);
    end
    mon_on = 0;
    chk("N=1 edges all seen", exp_q.size(), 0);

    // Offer N=7 on a TC cycle: it must go pending, then reset drops it.
    bus.cfg_valid = 1; bus.cfg_div = 4'd7;
    step();
    bus.cfg_valid = 0;
    chk("pending cfg_ready", bus.cfg_ready, 0);
    #1 rst = 1;
    #1;
    chk("async rst clk_out", bus.clk_out, 0);
    chk("async rst tick", bus.tick, 0);
    chk("async rst busy", bus.busy, 0);
    chk("async rst cfg_ready", bus.cfg_ready, 1);
    chk("async rst cfg_err", bus.cfg_err, 0);
    chk("async rst div", dut.div, 5);
    bus.en = 0;
    #4 rst = 0;
    step();
    bus.en = 1;
    step();                     // enters RUN with default divisor
    n = 0;
    while (bus.clk_out !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("first rise after rst (N=5)", n, 5);
    chk("first rise tick", bus.tick, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
